// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Full hex glyph table, indexed by digit value 0..F
    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder (active-low outputs).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_TABLE[value];
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment scan driver with registered active-low outputs.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     an,
    output seg_t                  seg,
    output logic                  dp_n,
    output logic                  frame
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0] pre;
    logic [IW-1:0] idx;
    logic [3:0]    cur;
    logic          cur_dp;
    logic          cur_blank;
    logic          upper_zero;
    logic          last_pre;
    logic          last_idx;
    seg_t          decoded;
    seg_t          seg_next;

    // Select the active digit, its dp request and whether it is a leading zero
    always_comb begin
        cur        = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (digits[4*k +: 4] == 4'h0);
            if (idx == IW'(k)) begin
                cur    = digits[4*k +: 4];
                cur_dp = dp[k];
`ifdef LZ_BLANK_EN
                cur_blank = (k > 0) && upper_zero;
`else
                cur_blank = 1'b0;
`endif
            end
        end
    end

    seg7_decode u_decode (
        .value (cur),
        .seg   (decoded)
    );

    assign seg_next = cur_blank ? SEG_BLANK : decoded;
    assign last_pre = (pre == PW'(DIV - 1));
    assign last_idx = (idx == IW'(DIGITS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            pre   <= '0;
            idx   <= '0;
            an    <= '1;
            seg   <= SEG_BLANK;
            dp_n  <= 1'b1;
            frame <= 1'b0;
        end else if (en) begin
            an    <= ~(DIGITS'(1) << idx);
            seg   <= seg_next;
            dp_n  <= ~cur_dp;
            frame <= last_pre && last_idx;
            if (last_pre) begin
                pre <= '0;
                idx <= last_idx ? '0 : idx + IW'(1);
            end else begin
                pre <= pre + PW'(1);
            end
        end else begin
            an    <= '1;
            seg   <= SEG_BLANK;
            dp_n  <= 1'b1;
            frame <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with DIGITS=4, DIV=2.
// Leading-zero expectations follow LZ_BLANK_EN when it is defined.
module tb_seg7_scan;

    logic        clock;
    logic        reset;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame;

    int errorCount = 0;
    int checkCount = 0;

    logic [3:0] anSeq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    seg7_scan #(.DIGITS(4), .DIV(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .en     (en),
        .digits (digits),
        .dp     (dp),
        .an     (an),
        .seg    (seg),
        .dp_n   (dp_n),
        .frame  (frame)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [15:0] d, input logic [3:0] p);
        reset  = r;
        en     = e;
        digits = d;
        dp     = p;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] expAn,
                            input logic [6:0] expSeg, input logic expDpN,
                            input logic expFrame);
        checkOutput({tag, ".an"},    32'(an),    32'(expAn));
        checkOutput({tag, ".seg"},   32'(seg),   32'(expSeg));
        checkOutput({tag, ".dp_n"},  32'(dp_n),  32'(expDpN));
        checkOutput({tag, ".frame"}, 32'(frame), 32'(expFrame));
    endtask

    initial begin
        logic [6:0] segA [4];
        logic [6:0] segB [4];
        logic [6:0] segC [4];
        int frameCount;

        // Reset held three cycles, then first frame of 0128
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0128, 4'h0);
            checkAll($sformatf("rst%0d", i), 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        segA = '{7'h00, 7'h24, 7'h79, 7'h40};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
            checkAll($sformatf("scan%0d", i), anSeq[i/2], segA[i/2], 1'b1, i == 7);
        end

        // Three more frames: frame pulse once per eight cycles on digit 3
        frameCount = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
            checkOutput($sformatf("frm%0d", i), 32'(frame), 32'(i % 8 == 7));
            if (frame) begin
                frameCount++;
                checkOutput($sformatf("frmAn%0d", i), 32'(an), 32'h7);
            end
        end
        checkOutput("frameCount", 32'(frameCount), 32'd3);

        // Freeze during the first cycle of digit 2
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
        checkOutput("preFreezeAn", 32'(an), 32'hB);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0128, 4'h0);
            checkAll($sformatf("frz%0d", i), 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
        checkAll("resume0", 4'hB, 7'h79, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
        checkAll("resume1", 4'h7, 7'h40, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
        checkAll("resume2", 4'h7, 7'h40, 1'b1, 1'b1);

        // Full hex glyphs with a decimal point on digit 2
        applyStimulus(1'b1, 1'b1, 16'hFA93, 4'b0100);
        checkAll("rstB", 4'hF, 7'h7F, 1'b1, 1'b0);
        segB = '{7'h30, 7'h10, 7'h08, 7'h0E};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 16'hFA93, 4'b0100);
            checkAll($sformatf("hex%0d", i), anSeq[i/2], segB[i/2], i/2 != 2, i == 7);
        end

        // Leading zeros
        applyStimulus(1'b1, 1'b1, 16'h0005, 4'h0);
`ifdef LZ_BLANK_EN
        segC = '{7'h12, 7'h7F, 7'h7F, 7'h7F};
`else
        segC = '{7'h12, 7'h40, 7'h40, 7'h40};
`endif
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0005, 4'h0);
            checkAll($sformatf("lz%0d", i), anSeq[i/2], segC[i/2], 1'b1, i == 7);
        end

        // Reset pulse while digit 3 is lit
        applyStimulus(1'b1, 1'b1, 16'h0128, 4'h0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
        checkOutput("preRstAn", 32'(an), 32'h7);
        applyStimulus(1'b1, 1'b1, 16'h0128, 4'h0);
        checkAll("midRst", 4'hF, 7'h7F, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
        checkAll("restart0", 4'hE, 7'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
        checkAll("restart1", 4'hE, 7'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0128, 4'h0);
        checkAll("restart2", 4'hD, 7'h24, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed seven-segment display driver for DIGITS packed 4-bit digit values, such as the outputs of one or more mod-9 display counters. The block scans one digit at a time. It drives active-low anode enables and active-low segment lines, and emits a one-cycle pulse at the end of each scan frame. It is the display stage directly downstream of the counter blocks in the simulation examples.

## Interface
- DIGITS, 4: number of digits scanned; legal range 1..8.
- DIV, 4: clock cycles each digit stays lit; legal range ≥1.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 freezes the scan and blanks the display.
- digits  in  4*DIGITS  packed digit values; digit k is digits[4k+3:4k]; digit 0 is rightmost.
- dp  in  DIGITS  decimal point request per digit, active-high.
- an  out  DIGITS  anode enables, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point segment, active-low.
- frame  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Internal state:
  - prescaler pre: width max(1,$clog2(DIV)), counts 0..DIV-1.
  - digit index idx: width max(1,$clog2(DIGITS)), counts 0..DIGITS-1.
- Every posedge with en=1:
  - If pre==DIV-1: pre←0 and idx advances (DIGITS-1 wraps to 0).
  - Otherwise: pre←pre+1.
- Outputs are registered and loaded every cycle from the pre-update idx and the current inputs:
  - an←~(1<<idx)
  - seg←decode(digits[idx])
  - dp_n←~dp[idx]
  - frame←(pre==DIV-1 && idx==DIGITS-1)
- Decode is full hex, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- en=0:
  - pre and idx hold.
  - Next edge forces an=all ones, seg=7F, dp_n=1, frame=0.
  - Scan resumes from the held idx/pre when en returns to 1.
- Input changes during a digit slot take effect on the next edge. There is no input latching.
- DIV=1: idx advances every cycle. DIGITS=1: an is permanently 0 while enabled, and frame pulses every DIV cycles.

## Timing
- Reset values: pre=0, idx=0, an=all ones, seg=7F, dp_n=1, frame=0.
- reset has priority over en. Reset mid-scan returns to digit 0 on the next edge with all outputs blank.
- Output latency: one cycle from idx to an/seg/dp_n.
- First enabled edge after reset drives digit 0. Each digit stays lit for exactly DIV consecutive cycles.
- Frame period: DIGITS*DIV cycles.
- frame is high in the cycle in which idx has just wrapped to 0, while an still shows digit DIGITS-1.

## Configuration
- LZ_BLANK_EN defined (leading-zero blanking):
  - Digit k>0 shows seg=7F when digits k..DIGITS-1 are all zero.
  - The anode is still driven for that slot, and dp_n is unaffected.
  - Digit 0 is never blanked.
- LZ_BLANK_EN undefined: every digit is decoded normally, including leading zeros.

## Structure
- Package seg7_pkg holds:
  - the SEG_BLANK=7'h7F constant
  - the 16-entry hex segment table (active-low, gfedcba order)
  - a typedef seg_t for logic [6:0]
- Sub-module seg7_decode is purely combinational: 4-bit value in, seg_t out. seg7_scan instantiates it once on the selected digit.

## Test plan
All cases use DIGITS=4, DIV=2 unless stated.
1. Reset held 3 cycles, then released with en=1 and digits=16'h0128 -> an=1111, seg=7F during reset. Next edges show an=1110/seg=00 for 2 cycles, then 1101/24, then 1011/79, then 0111/40.
2. Run 3 full frames -> frame high exactly once per 8 cycles, coincident with an=0111 on its second cycle.
3. Drop en for 5 cycles mid-digit-2, then raise it -> an=1111 and seg=7F while low. Digit 2 resumes and completes only its remaining cycles.
4. digits=16'hFA93 with dp=4'b0100 -> seg sequence 30, 10, 08, 0E. dp_n=0 only while an=1011.
5. With LZ_BLANK_EN, digits=16'h0005 -> digit 0 seg=12; digits 1–3 seg=7F with anodes still cycling. Without LZ_BLANK_EN, digits 1–3 show seg=40.
6. Assert reset for 1 cycle during digit 3 -> next edge all outputs blank. Scan restarts at digit 0 with a full DIV-cycle slot.
